// File: rtl/mips_pkg.sv
// Constants and helpers shared by the fetch stage and the decode controller
// of the 5-stage MIPS pipeline.
package mips_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JAL    = 2'd2,
    NPC_JR     = 2'd3
  } npc_sel_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the fetch stage. Redirects are resolved
// against the instruction in D, so branch/jump targets are relative to PC_D.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_d_i,
  input  logic        beq_i,
  input  logic        jal_i,
  input  logic        jr_i,
  input  logic        cmp_eq_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] index_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] npc_o
);

  npc_sel_e sel;

  // jr wins over jal, which wins over a taken beq, when several are raised.
  always_comb begin
    sel = NPC_SEQ;
    if (jr_i)                 sel = NPC_JR;
    else if (jal_i)           sel = NPC_JAL;
    else if (beq_i && cmp_eq_i) sel = NPC_BRANCH;
  end

  always_comb begin
    npc_o = pc_f_i + 32'd4;
    case (sel)
      NPC_JR:     npc_o = rs_val_i;
      NPC_JAL:    npc_o = {pc_d_i[31:28], index_i, 2'b00};
      NPC_BRANCH: npc_o = pc_d_i + 32'd4 + branch_offset(imm_i);
      default:    npc_o = pc_f_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/f_stage_fd_reg.sv
// Fetch stage with the F/D pipeline register: architectural PC, IM address,
// latched instruction/PC for decode and a count of instructions taken into D.
module f_stage_fd_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      instr_F,
  input  logic             beq_D,
  input  logic             jal_D,
  input  logic             jr_D,
  input  logic             cmp_eq_D,
  input  logic [15:0]      imm_D,
  input  logic [25:0]      index_D,
  input  logic [31:0]      rs_val_D,
  output logic [31:0]      pc_F,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      INSTR_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC8_D,
  output logic [31:0]      fetch_cnt
);

  logic [31:0] pc_f_q,  pc_f_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_d_q,  pc_d_d;
  logic [31:0] cnt_q,   cnt_d;
  logic [31:0] npc;
  logic [31:0] im_offset;

  npc_calc u_npc_calc (
    .pc_f_i   (pc_f_q),
    .pc_d_i   (pc_d_q),
    .beq_i    (beq_D),
    .jal_i    (jal_D),
    .jr_i     (jr_D),
    .cmp_eq_i (cmp_eq_D),
    .imm_i    (imm_D),
    .index_i  (index_D),
    .rs_val_i (rs_val_D),
    .npc_o    (npc)
  );

  // The delay-slot word is never flushed: on a redirect it still moves into D
  // while pc_F takes the target. A stall freezes everything, so a redirect
  // raised during the stall is simply re-evaluated when it lifts.
  always_comb begin
    pc_f_d  = pc_f_q;
    instr_d = instr_q;
    pc_d_d  = pc_d_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      pc_f_d  = npc;
      instr_d = instr_F;
      pc_d_d  = pc_f_q;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f_q  <= PC_RESET;
      instr_q <= NOP_WORD;
      pc_d_q  <= PC_RESET;
      cnt_q   <= 32'd0;
    end else begin
      pc_f_q  <= pc_f_d;
      instr_q <= instr_d;
      pc_d_q  <= pc_d_d;
      cnt_q   <= cnt_d;
    end
  end

  // Out-of-range fetches wrap modulo the IM size; bits [1:0] are dropped.
  assign im_offset = pc_f_q - PC_RESET;
  assign im_addr   = im_offset[IM_AW+1:2];

  assign pc_F      = pc_f_q;
  assign INSTR_D   = instr_q;
  assign PC_D      = pc_d_q;
  assign PC8_D     = pc_d_q + 32'd8;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_f_stage_fd_reg.sv
// Directed bench for f_stage_fd_reg: expected F/D state is queued per step
// and compared after the clock edge.
module tb_f_stage_fd_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] instr_F;
  logic        beq_D, jal_D, jr_D, cmp_eq_D;
  logic [15:0] imm_D;
  logic [25:0] index_D;
  logic [31:0] rs_val_D;
  logic [31:0] pc_F;
  logic [11:0] im_addr;
  logic [31:0] INSTR_D, PC_D, PC8_D, fetch_cnt;

  logic [31:0] im [4096];

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  assign instr_F = im[im_addr];

  f_stage_fd_reg #(.PC_RESET(32'h0000_3000), .IM_AW(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .instr_F   (instr_F),
    .beq_D     (beq_D),
    .jal_D     (jal_D),
    .jr_D      (jr_D),
    .cmp_eq_D  (cmp_eq_D),
    .imm_D     (imm_D),
    .index_D   (index_D),
    .rs_val_D  (rs_val_D),
    .pc_F      (pc_F),
    .im_addr   (im_addr),
    .INSTR_D   (INSTR_D),
    .PC_D      (PC_D),
    .PC8_D     (PC8_D),
    .fetch_cnt (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pcd, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.instr = instr; e.pcd = pcd; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // One clock, then compare the DUT against the oldest queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc_F"},      pc_F,      e.pc);
      check({e.tag, ".INSTR_D"},   INSTR_D,   e.instr);
      check({e.tag, ".PC_D"},      PC_D,      e.pcd);
      check({e.tag, ".fetch_cnt"}, fetch_cnt, e.cnt);
      $display("[TB] %s pc_F=%h INSTR_D=%h PC_D=%h cnt=%0d", e.tag, pc_F, INSTR_D, PC_D, fetch_cnt);
    end
  endtask

  task automatic clear_redirect();
    beq_D = 0; jal_D = 0; jr_D = 0; cmp_eq_D = 0;
    imm_D = '0; index_D = '0; rs_val_D = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) im[i] = 32'hA000_0000 + i;
    im[0] = 32'h11; im[1] = 32'h22; im[2] = 32'h33;

    reset = 0; stall = 0;
    clear_redirect();

    // reset state
    expect_state("reset", 32'h3000, 32'h0, 32'h3000, 0);
    step();
    check("reset.im_addr", {20'h0, im_addr}, 32'h0);
    check("reset.PC8_D", PC8_D, 32'h3008);

    // free-running fetch
    reset = 1;
    expect_state("adv1", 32'h3004, 32'h11, 32'h3000, 1); step();
    expect_state("adv2", 32'h3008, 32'h22, 32'h3004, 2); step();
    check("adv2.im_addr", {20'h0, im_addr}, 32'h2);

    // stall holds everything, even with instr_F changing underneath
    stall = 1;
    expect_state("stall1", 32'h3008, 32'h22, 32'h3004, 2); step();
    expect_state("stall2", 32'h3008, 32'h22, 32'h3004, 2); step();
    stall = 0;
    expect_state("resume", 32'h300C, 32'h33, 32'h3008, 3); step();

    // beq taken from PC_D=0x3004 with imm=-1: target 0x3004, delay slot 0x3008 enters D
    reset = 0; expect_state("rst2", 32'h3000, 32'h0, 32'h3000, 0); step();
    reset = 1;
    expect_state("pre_beq1", 32'h3004, 32'h11, 32'h3000, 1); step();
    expect_state("pre_beq2", 32'h3008, 32'h22, 32'h3004, 2); step();
    beq_D = 1; cmp_eq_D = 1; imm_D = 16'hFFFF;
    expect_state("beq_taken", 32'h3004, 32'h33, 32'h3008, 3); step();
    clear_redirect();
    expect_state("post_beq", 32'h3008, 32'h22, 32'h3004, 4); step();
    beq_D = 1; cmp_eq_D = 0; imm_D = 16'hFFFF;
    expect_state("beq_not_taken", 32'h300C, 32'h33, 32'h3008, 5); step();
    clear_redirect();

    // jal from PC_D=0x3010
    expect_state("pre_jal1", 32'h3010, 32'hA000_0003, 32'h300C, 6); step();
    expect_state("pre_jal2", 32'h3014, 32'hA000_0004, 32'h3010, 7); step();
    check("jal.PC8_D", PC8_D, 32'h3018);
    jal_D = 1; index_D = 26'h0000C10;
    expect_state("jal", 32'h3040, 32'hA000_0005, 32'h3014, 8); step();
    clear_redirect();

    // jr to 0x3100
    jr_D = 1; rs_val_D = 32'h3100;
    expect_state("jr", 32'h3100, 32'hA000_0010, 32'h3040, 9); step();
    check("jr.im_addr", {20'h0, im_addr}, 32'h40);

    // jr raised during stall is held off, then uses rs_val_D of the release cycle
    stall = 1; jr_D = 1; rs_val_D = 32'h3200;
    expect_state("jr_stall", 32'h3100, 32'hA000_0010, 32'h3040, 9); step();
    stall = 0; rs_val_D = 32'h3204;
    expect_state("jr_release", 32'h3204, 32'hA000_0040, 32'h3100, 10); step();
    clear_redirect();

    // jr has priority over jal; misaligned target loaded as-is
    jr_D = 1; jal_D = 1; index_D = 26'h0000C10; rs_val_D = 32'h3006;
    expect_state("jr_over_jal", 32'h3006, 32'hA000_0081, 32'h3204, 11); step();
    check("misaligned.im_addr", {20'h0, im_addr}, 32'h1);
    clear_redirect();

    // pc_F + 4 wraps to zero; out-of-range im_addr wraps modulo IM size
    jr_D = 1; rs_val_D = 32'hFFFF_FFFC;
    expect_state("jr_top", 32'hFFFF_FFFC, 32'h22, 32'h3006, 12); step();
    check("top.im_addr", {20'h0, im_addr}, 32'h3FF);
    clear_redirect();
    expect_state("pc_wrap", 32'h0, 32'hA000_03FF, 32'hFFFF_FFFC, 13); step();
    check("wrap.im_addr", {20'h0, im_addr}, 32'h400);
    check("wrap.PC8_D", PC8_D, 32'h4);

    // reset overrides stall and a pending jal
    reset = 0; stall = 1; jal_D = 1; index_D = 26'h0000C10;
    expect_state("rst_mid_stall", 32'h3000, 32'h0, 32'h3000, 0); step();
    reset = 1; stall = 0; clear_redirect();
    expect_state("after_rst", 32'h3004, 32'h11, 32'h3000, 1); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
